// File: rtl/axis_uart_tx_arbiter_if.sv
// Bundle of the per-source AXI-Stream request lanes and the single stream
// towards the UART TX slave. The "slave" modport is the arbiter's view (it
// consumes the source lanes and drives the UART stream); the "master" modport
// is the view of whoever drives the sources and sinks the UART stream.
interface axis_uart_tx_arbiter_if #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_BITS = 8
);
    logic [NUM_SRC*DATA_BITS-1:0] s_axis_data;
    logic [NUM_SRC-1:0]           s_axis_valid;
    logic [NUM_SRC-1:0]           s_axis_last;
    logic [NUM_SRC-1:0]           s_axis_ready;
    logic [DATA_BITS-1:0]         m_axis_data;
    logic                         m_axis_valid;
    logic                         m_axis_last;
    logic                         m_axis_ready;

    modport master (
        output s_axis_data,
        output s_axis_valid,
        output s_axis_last,
        output m_axis_ready,
        input  s_axis_ready,
        input  m_axis_data,
        input  m_axis_valid,
        input  m_axis_last
    );

    modport slave (
        input  s_axis_data,
        input  s_axis_valid,
        input  s_axis_last,
        input  m_axis_ready,
        output s_axis_ready,
        output m_axis_data,
        output m_axis_valid,
        output m_axis_last
    );
endinterface

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the UART TX stream.
// A source keeps the grant from its first beat until the beat carrying last,
// so packets never interleave on the UART. A watchdog releases a granted
// source that stops presenting data mid-packet for MAX_GAP cycles, so one dead
// requester cannot lock the UART for everybody else.
module axis_uart_tx_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_GAP   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_uart_tx_arbiter_if.slave      axis,
    output logic [$clog2(NUM_SRC)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       timeout_err_o
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int GAP_W = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SRC - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     rrPtr_q;
    logic [IDX_W-1:0]     grantId_q;
    logic [GAP_W-1:0]     gapCnt_q;
    logic                 timeoutErr_q;

    logic                 grantValid;
    logic                 grantLast;
    logic [DATA_BITS-1:0] grantData;

    logic                 pickValid_d;
    logic [IDX_W-1:0]     pickIdx_d;
    logic [IDX_W:0]       cand;
    logic [IDX_W-1:0]     nextPtr_d;

    logic [NUM_SRC-1:0]   sReady;
    logic [DATA_BITS-1:0] mData;
    logic                 mValid;
    logic                 mLast;

    // Lane of the currently granted source, used by both the output mux and the FSM
    always_comb begin
        grantValid = axis.s_axis_valid[grantId_q];
        grantLast  = axis.s_axis_last[grantId_q];
        grantData  = axis.s_axis_data[grantId_q*DATA_BITS +: DATA_BITS];
    end

    // Round-robin search: first requesting source at or after rrPtr_q, wrapping
    // modulo NUM_SRC; scanning from the far end lets the nearest hit win
    always_comb begin
        pickValid_d = 1'b0;
        pickIdx_d   = '0;
        cand        = '0;
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            cand = {1'b0, rrPtr_q} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(NUM_SRC)) begin
                cand = cand - (IDX_W+1)'(NUM_SRC);
            end
            if (axis.s_axis_valid[cand[IDX_W-1:0]]) begin
                pickValid_d = 1'b1;
                pickIdx_d   = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer to the source after the granted one, where the next search starts
    always_comb begin
        nextPtr_d = (grantId_q == IDX_LAST) ? '0 : grantId_q + 1'b1;
    end

    // Pass-through mux while transferring; everything is quiet while idle
    always_comb begin
        sReady = '0;
        mData  = '0;
        mValid = 1'b0;
        mLast  = 1'b0;
        if (state_q == XFER) begin
            sReady[grantId_q] = axis.m_axis_ready;
            mData             = grantData;
            mValid            = grantValid;
            mLast             = grantLast;
        end
    end

    assign axis.s_axis_ready = sReady;
    assign axis.m_axis_data  = mData;
    assign axis.m_axis_valid = mValid;
    assign axis.m_axis_last  = mLast;

    // Grant FSM: takes a packet from the chosen source, releases on the last
    // beat or when the watchdog sees MAX_GAP consecutive empty cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rrPtr_q      <= '0;
            grantId_q    <= '0;
            gapCnt_q     <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            timeoutErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pickValid_d) begin
                        grantId_q <= pickIdx_d;
                        gapCnt_q  <= '0;
                        state_q   <= XFER;
                    end
                end
                XFER: begin
                    if (grantValid) begin
                        gapCnt_q <= '0;
                        if (axis.m_axis_ready && grantLast) begin
                            state_q <= IDLE;
                            rrPtr_q <= nextPtr_d;
                        end
                    end else if (gapCnt_q == GAP_LAST) begin
                        timeoutErr_q <= 1'b1;
                        state_q      <= IDLE;
                        rrPtr_q      <= nextPtr_d;
                        gapCnt_q     <= '0;
                    end else begin
                        gapCnt_q <= gapCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_id_o    = grantId_q;
    assign busy_o        = (state_q == XFER);
    assign timeout_err_o = timeoutErr_q;

endmodule
